// File: rtl/cache_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cache_pkg
//  Description : Shared types and constants for the cache refill responder.
//                fill_state_t - refill FSM state encoding
//                LINE_WORDS   - default words per cache line
//                WORD_BYTES   - bytes per cache word (16-bit words)
//                OFFSET_BITS  - byte-offset bits inside one line
//  Revision    : 1.0 - initial release
// ============================================================================
package cache_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        FILL = 1'b1
    } fill_state_t;

    localparam int LINE_WORDS  = 8;
    localparam int WORD_BYTES  = 2;
    localparam int OFFSET_BITS = $clog2(LINE_WORDS * WORD_BYTES);

endpackage
`default_nettype wire

// File: rtl/cache_fill_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : cache_fill_fsm
//  Description : Cache miss refill responder. On a miss it streams one full
//                line from main memory (one request per cycle), writes every
//                returned word into the cache data array and writes the tag
//                together with the last word. fsm_busy stalls the core.
//  Ports       : clk, rst            - clock, async active-high reset
//                miss_detected       - lookup missed this cycle
//                miss_address        - byte address that missed
//                fsm_busy            - refill in progress (stall)
//                memory_read_en      - issue a memory read this cycle
//                memory_address      - byte address of the issued read
//                memory_data_valid   - memory returns a word (request order)
//                memory_data         - returned word
//                write_data_array    - write cache_wr_data at cache_wr_addr
//                cache_wr_addr       - byte address of the word being filled
//                cache_wr_data       - pass-through of memory_data
//                write_tag_array     - write tag/valid for the line
//  Revision    : 1.0 - initial release
// ============================================================================
module cache_fill_fsm
    import cache_pkg::*;
#(
    parameter int ADDR_W     = 16,
    parameter int LINE_WORDS = cache_pkg::LINE_WORDS,
    parameter int MEM_LAT    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              miss_detected,
    input  logic [ADDR_W-1:0] miss_address,
    output logic              fsm_busy,
    output logic              memory_read_en,
    output logic [ADDR_W-1:0] memory_address,
    input  logic              memory_data_valid,
    input  logic [15:0]       memory_data,
    output logic              write_data_array,
    output logic [ADDR_W-1:0] cache_wr_addr,
    output logic [15:0]       cache_wr_data,
    output logic              write_tag_array
);

    // Counters carry one extra bit so the issue side can reach LINE_WORDS.
    localparam int                 c_cnt_w    = $clog2(LINE_WORDS) + 1;
    localparam int                 c_off_w    = $clog2(LINE_WORDS * WORD_BYTES);
    localparam logic [ADDR_W-1:0]  c_off_mask = ADDR_W'((1 << c_off_w) - 1);
    localparam logic [c_cnt_w-1:0] c_words    = c_cnt_w'(LINE_WORDS);
    localparam logic [c_cnt_w-1:0] c_last     = c_cnt_w'(LINE_WORDS - 1);

    // Elaboration-time parameter sanity checks.
    if ((LINE_WORDS < 2) || ((LINE_WORDS & (LINE_WORDS - 1)) != 0)) begin : g_bad_line_words
        $error("cache_fill_fsm: LINE_WORDS must be a power of two >= 2");
    end
    if (MEM_LAT < 1) begin : g_bad_mem_lat
        $error("cache_fill_fsm: MEM_LAT must be at least 1");
    end

    fill_state_t        r_state;
    fill_state_t        w_state_nxt;
    logic [c_cnt_w-1:0] r_issue_cnt;
    logic [c_cnt_w-1:0] w_issue_nxt;
    logic [c_cnt_w-1:0] r_rcv_cnt;
    logic [c_cnt_w-1:0] w_rcv_nxt;
    logic [ADDR_W-1:0]  r_line_base;
    logic [ADDR_W-1:0]  w_base_nxt;

    logic [c_cnt_w-1:0] w_issue_idx;
    logic [ADDR_W-1:0]  w_issue_addr;
    logic [ADDR_W-1:0]  w_rcv_addr;
    logic [ADDR_W-1:0]  w_miss_base;

    // Once all requests are out the address parks on the last word instead
    // of running one word past the line.
    assign w_issue_idx  = (r_issue_cnt < c_words) ? r_issue_cnt : c_last;
    assign w_issue_addr = r_line_base + ADDR_W'(WORD_BYTES) * ADDR_W'(w_issue_idx);
    assign w_rcv_addr   = r_line_base + ADDR_W'(WORD_BYTES) * ADDR_W'(r_rcv_cnt);
    assign w_miss_base  = miss_address & ~c_off_mask;

    assign cache_wr_data = memory_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_issue_cnt <= '0;
            r_rcv_cnt   <= '0;
            r_line_base <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_issue_cnt <= w_issue_nxt;
            r_rcv_cnt   <= w_rcv_nxt;
            r_line_base <= w_base_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_issue_nxt      = r_issue_cnt;
        w_rcv_nxt        = r_rcv_cnt;
        w_base_nxt       = r_line_base;
        fsm_busy         = 1'b0;
        memory_read_en   = 1'b0;
        memory_address   = '0;
        write_data_array = 1'b0;
        cache_wr_addr    = '0;
        write_tag_array  = 1'b0;

        unique case (r_state)
            IDLE: begin
                // Stall starts combinationally in the miss cycle itself.
                fsm_busy = miss_detected;
                if (miss_detected) begin
                    w_state_nxt = FILL;
                    w_base_nxt  = w_miss_base;
                    w_issue_nxt = '0;
                    w_rcv_nxt   = '0;
                end
            end

            FILL: begin
                fsm_busy       = 1'b1;
                memory_address = w_issue_addr;
                if (r_issue_cnt < c_words) begin
                    memory_read_en = 1'b1;
                    w_issue_nxt    = r_issue_cnt + c_cnt_w'(1);
                end

                if (memory_data_valid) begin
                    write_data_array = 1'b1;
                    cache_wr_addr    = w_rcv_addr;
                    w_rcv_nxt        = r_rcv_cnt + c_cnt_w'(1);
                    if (r_rcv_cnt == c_last) begin
                        write_tag_array = 1'b1;
                        // A miss presented in the completion cycle chains
                        // straight into the next refill so busy never drops.
                        if (miss_detected) begin
                            w_base_nxt  = w_miss_base;
                            w_issue_nxt = '0;
                            w_rcv_nxt   = '0;
                        end else begin
                            w_state_nxt = IDLE;
                        end
                    end
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_cache_fill_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cache_fill_fsm
//  Description : Scoreboard bench for cache_fill_fsm. A line-level reference
//                model queues the expected requests and writes for every
//                accepted miss; a negedge monitor pops and compares them.
//                A memory model returns words with latency and random gaps.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_fill_fsm;

    localparam int ADDR_W  = 16;
    localparam int LW      = 8;
    localparam int MEM_LAT = 4;

    logic              clk;
    logic              rst;
    logic              miss_detected;
    logic [ADDR_W-1:0] miss_address;
    logic              fsm_busy;
    logic              memory_read_en;
    logic [ADDR_W-1:0] memory_address;
    logic              memory_data_valid;
    logic [15:0]       memory_data;
    logic              write_data_array;
    logic [ADDR_W-1:0] cache_wr_addr;
    logic [15:0]       cache_wr_data;
    logic              write_tag_array;

    cache_fill_fsm #(
        .ADDR_W     (ADDR_W),
        .LINE_WORDS (LW),
        .MEM_LAT    (MEM_LAT)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .miss_detected     (miss_detected),
        .miss_address      (miss_address),
        .fsm_busy          (fsm_busy),
        .memory_read_en    (memory_read_en),
        .memory_address    (memory_address),
        .memory_data_valid (memory_data_valid),
        .memory_data       (memory_data),
        .write_data_array  (write_data_array),
        .cache_wr_addr     (cache_wr_addr),
        .cache_wr_data     (cache_wr_data),
        .write_tag_array   (write_tag_array)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle++;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // ---------------- memory model ----------------
    logic [15:0] mem_seed;
    int          gap_pct = 0;

    typedef struct {
        logic [15:0] addr;
        int          due;
    } pend_t;
    pend_t pend[$];

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        logic [15:0] p;
        p = a * 16'h9E37;
        return p ^ mem_seed;
    endfunction

    always begin
        @(posedge clk);
        #1;
        if (pend.size() > 0 && pend[0].due <= cycle && $urandom_range(99) >= gap_pct) begin
            memory_data_valid = 1'b1;
            memory_data       = mem_word(pend[0].addr);
            void'(pend.pop_front());
        end else begin
            memory_data_valid = 1'b0;
            memory_data       = 16'($urandom);
        end
    end

    // ---------------- reference model + scoreboard ----------------
    typedef struct {
        logic [15:0] addr;
        logic [15:0] data;
        bit          last;
    } wr_t;

    logic [15:0] exp_req[$];
    wr_t         exp_wr[$];
    bit          m_active = 0;
    int          m_issued = 0;
    int          m_rcv    = 0;
    logic [15:0] m_base   = '0;

    task automatic model_start(input logic [15:0] a);
        wr_t e;
        m_active = 1;
        m_base   = a & 16'hFFF0;
        m_issued = 0;
        m_rcv    = 0;
        for (int i = 0; i < LW; i++) begin
            exp_req.push_back(m_base + 16'(2 * i));
            e.addr = m_base + 16'(2 * i);
            e.data = mem_word(e.addr);
            e.last = (i == LW - 1);
            exp_wr.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        bit  exp_rd;
        bit  exp_we;
        wr_t e;
        logic [15:0] r;
        if (rst) begin
            m_active = 0;
            exp_req.delete();
            exp_wr.delete();
            check("rst_busy",  fsm_busy, miss_detected);
            check("rst_rd_en", memory_read_en, 0);
            check("rst_maddr", memory_address, 0);
            check("rst_we",    write_data_array, 0);
            check("rst_waddr", cache_wr_addr, 0);
            check("rst_tag",   write_tag_array, 0);
        end else begin
            exp_rd = m_active && (m_issued < LW);
            exp_we = m_active && memory_data_valid;
            check("busy",    fsm_busy, m_active || miss_detected);
            check("read_en", memory_read_en, exp_rd);
            if (memory_read_en && exp_rd) begin
                r = exp_req.pop_front();
                check("mem_addr", memory_address, r);
            end else if (m_active && !exp_rd) begin
                check("mem_addr_hold", memory_address, m_base + 16'(2 * (LW - 1)));
            end
            check("wr_en", write_data_array, exp_we);
            if (write_data_array && exp_we) begin
                e = exp_wr.pop_front();
                check("wr_addr", cache_wr_addr, e.addr);
                check("wr_data", cache_wr_data, e.data);
                check("tag",     write_tag_array, e.last);
            end else begin
                check("tag_idle", write_tag_array, 0);
            end
            if (m_active) begin
                if (exp_rd) m_issued++;
                if (memory_data_valid) m_rcv++;
                if (m_rcv == LW) m_active = 0;
            end
            if (!m_active && miss_detected) model_start(miss_address);
        end
        if (memory_read_en) pend.push_back('{memory_address, cycle + MEM_LAT - 1});
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        while ((pend.size() > 0 || m_active) && n < 200) begin
            step();
            n++;
        end
        if (n >= 200) check("drain_timeout", 1, 0);
        step();
    endtask

    // Present a miss at relative cycle 0, optionally another at second_at,
    // and measure how many consecutive cycles fsm_busy is high.
    task automatic run_fill(input logic [15:0] a, input int gap, input int second_at,
                            input logic [15:0] a2, input int exp_len);
        int len  = 0;
        int n    = 0;
        bit done = 0;
        gap_pct = gap;
        miss_detected = 1'b1;
        miss_address  = a;
        while (!done && n < 300) begin
            @(negedge clk);
            if (fsm_busy) len++;
            else done = 1;
            if (!done) begin
                step();
                n++;
                miss_detected = (n == second_at);
                if (n == second_at) miss_address = a2;
            end
        end
        miss_detected = 1'b0;
        if (!done) check("busy_timeout", 1, 0);
        if (exp_len > 0) check("busy_len", len, exp_len);
        drain();
    endtask

    initial begin
        mem_seed          = 16'($urandom);
        rst               = 1'b1;
        miss_detected     = 1'b0;
        miss_address      = '0;
        memory_data_valid = 1'b0;
        memory_data       = '0;
        repeat (3) step();
        rst = 1'b0;
        step();

        // Basic line fill, unaligned miss inside the line.
        run_fill(16'h0036, 0, -1, 16'h0, LW + MEM_LAT);
        // Top of address space: no wrap past 0xFFFE.
        run_fill(16'hFFFF, 0, -1, 16'h0, LW + MEM_LAT);
        // Miss during a fill is ignored, then re-presented.
        run_fill(16'h0040, 0, 3, 16'h1000, LW + MEM_LAT);
        run_fill(16'h1000, 0, -1, 16'h0, LW + MEM_LAT);
        // Back-to-back: second miss in the completion cycle of the first.
        run_fill(16'h0200, 0, LW + MEM_LAT - 1, 16'h0306, 2 * (LW + MEM_LAT) - 1);

        // Asynchronous reset in the middle of a refill.
        gap_pct       = 0;
        miss_detected = 1'b1;
        miss_address  = 16'h0080;
        step();
        miss_detected = 1'b0;
        repeat (4) step();
        #2 rst = 1'b1;
        #1;
        check("async_busy",  fsm_busy, 0);
        check("async_rd_en", memory_read_en, 0);
        check("async_we",    write_data_array, 0);
        check("async_tag",   write_tag_array, 0);
        step();
        rst = 1'b0;
        drain();

        // Randomised fills with gaps in the memory return stream.
        for (int i = 0; i < 8; i++) begin
            run_fill(16'($urandom), 40, -1, 16'h0, 0);
        end
        run_fill(16'h2468, 0, -1, 16'h0, LW + MEM_LAT);

        check("leftover", exp_req.size() + exp_wr.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #400000;
        fails++;
        $display("FAIL watchdog: actual=timeout required=finish");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
